// File: rtl/fifo_access_arbiter.sv
// Round-robin arbiter that shares one FIFO between two writers and one reader.
// It tracks FIFO occupancy itself. Define ARB_READ_PRIO_EN to let the reader take
// priority at or above the high watermark.
module fifo_access_arbiter #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int LVL_W  = 4,
    parameter int HI_WM  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr0_req,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_gnt,
    input  logic              wr1_req,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_gnt,
    input  logic              rd_req,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              fifo_en,
    output logic              fifo_rw,
    output logic [DATA_W-1:0] fifo_wdata,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    typedef enum logic [1:0] {IDLE, ISS_W0, ISS_W1, ISS_RD} state_t;
    typedef enum logic [1:0] {SRC_W0, SRC_W1, SRC_RD} src_t;

`ifdef ARB_READ_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] HI_WM_L = LVL_W'(HI_WM);

    state_t           state, state_nx;
    src_t             last, last_nx;
    logic [LVL_W-1:0] lvl_nx;
    logic             el_w0, el_w1, el_rd, prio_hit;

    // Level as it will be after the op being issued this cycle completes.
    always_comb begin
        lvl_nx = level;
        case (state)
            ISS_W0, ISS_W1: lvl_nx = level + LVL_W'(1);
            ISS_RD:         lvl_nx = level - LVL_W'(1);
            default:        lvl_nx = level;
        endcase
    end

    // The requester granted this cycle is masked so it cannot be granted twice.
    assign el_w0    = wr0_req && (lvl_nx < DEPTH_L) && (state != ISS_W0);
    assign el_w1    = wr1_req && (lvl_nx < DEPTH_L) && (state != ISS_W1);
    assign el_rd    = rd_req  && (lvl_nx != '0)     && (state != ISS_RD);
    assign prio_hit = PRIO_EN && el_rd && (lvl_nx >= HI_WM_L);

    always_comb begin
        state_nx = IDLE;
        last_nx  = last;
        if (prio_hit) begin
            state_nx = ISS_RD;
        end else begin
            case (last)
                SRC_W0: begin
                    if      (el_w1) state_nx = ISS_W1;
                    else if (el_rd) state_nx = ISS_RD;
                    else if (el_w0) state_nx = ISS_W0;
                end
                SRC_W1: begin
                    if      (el_rd) state_nx = ISS_RD;
                    else if (el_w0) state_nx = ISS_W0;
                    else if (el_w1) state_nx = ISS_W1;
                end
                default: begin
                    if      (el_w0) state_nx = ISS_W0;
                    else if (el_w1) state_nx = ISS_W1;
                    else if (el_rd) state_nx = ISS_RD;
                end
            endcase
        end
        case (state_nx)
            ISS_W0:  last_nx = SRC_W0;
            ISS_W1:  last_nx = SRC_W1;
            ISS_RD:  last_nx = SRC_RD;
            default: last_nx = last;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create ordering-dependent behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= SRC_RD;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            level    <= lvl_nx;
            full     <= (lvl_nx == DEPTH_L);
            empty    <= (lvl_nx == '0);
            rd_valid <= (state == ISS_RD);
        end
    end

    // Outputs decode straight from the state flops, so reset clears them at once.
    assign wr0_gnt    = (state == ISS_W0);
    assign wr1_gnt    = (state == ISS_W1);
    assign rd_gnt     = (state == ISS_RD);
    assign fifo_en    = (state != IDLE);
    assign fifo_rw    = wr0_gnt || wr1_gnt;
    assign fifo_wdata = wr0_gnt ? wr0_data : (wr1_gnt ? wr1_data : '0);
    assign rd_data    = fifo_rdata;

endmodule
